// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one 4-phase shift-add engine (d*1, d*3, d*7, d*8) among N_REQ requesters.
// Latency: phase-0 result valid the cycle after grant; no bubble between jobs; out_rdy low freezes all state.
module mult_sched #(
  parameter int N_REQ = 4,
  parameter int DW    = 8,
  parameter int OW    = 11,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*DW-1:0]   d_flat,
  output logic [N_REQ-1:0]      grant,
  output logic [OW-1:0]         out,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [IDW-1:0]        out_id,
  output logic [1:0]            out_phase,
  output logic                  busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]     state;
  logic [1:0]     phase;
  logic [DW-1:0]  d_reg;
  logic [IDW-1:0] last_id;

  logic           adv;
  logic           arb;
  logic           win_vld;
  logic [IDW-1:0] win_id;
  logic [DW-1:0]  win_d;
  logic [IDW-1:0] idx;

  logic [OW-1:0]  d_ext;
  logic [OW-1:0]  nxt;

  assign adv = !out_vld || out_rdy;
  assign arb = adv && ((state == IDLE) || (phase == 2'd3));

  // Walk from last_id+1 with explicit wrap so non-power-of-two N_REQ works.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    win_d   = '0;
    idx     = last_id;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (idx == IDW'(N_REQ - 1)) ? '0 : idx + 1'b1;
      if (req[idx] && !win_vld) begin
        win_vld = 1'b1;
        win_id  = idx;
        win_d   = d_flat[idx*DW +: DW];
      end
    end
  end

  assign d_ext = {{(OW-DW){1'b0}}, d_reg};

  always_comb begin
    case (phase)
      2'd0:    nxt = d_ext + (d_ext << 1);
      2'd1:    nxt = (d_ext << 3) - d_ext;
      default: nxt = d_ext << 3;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= '0;
      d_reg     <= '0;
      last_id   <= IDW'(N_REQ - 1);
      grant     <= '0;
      out       <= '0;
      out_vld   <= 1'b0;
      out_id    <= '0;
      out_phase <= '0;
      busy      <= 1'b0;
    end else begin
      grant <= '0;
      if (adv) begin
        if (arb) begin
          if (win_vld) begin
            grant     <= {{(N_REQ-1){1'b0}}, 1'b1} << win_id;
            d_reg     <= win_d;
            out       <= {{(OW-DW){1'b0}}, win_d};
            out_vld   <= 1'b1;
            out_phase <= 2'd0;
            out_id    <= win_id;
            last_id   <= win_id;
            state     <= RUN;
            phase     <= 2'd0;
            busy      <= 1'b1;
          end else begin
            // out deliberately keeps its last value when the engine goes idle
            state   <= IDLE;
            out_vld <= 1'b0;
            busy    <= 1'b0;
          end
        end else if (state == RUN) begin
          phase     <= phase + 2'd1;
          out_phase <= phase + 2'd1;
          out       <= nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
// Bench for mult_sched: job-level reference model compared every cycle, plus directed literal checks.
module tb_mult_sched;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int OW  = 11;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] d_flat = '0;
  logic            out_rdy = 1'b1;
  logic [N-1:0]    grant;
  logic [OW-1:0]   out;
  logic            out_vld;
  logic [IDW-1:0]  out_id;
  logic [1:0]      out_phase;
  logic            busy;

  mult_sched #(.N_REQ(N), .DW(DW), .OW(OW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req(req), .d_flat(d_flat), .grant(grant),
    .out(out), .out_vld(out_vld), .out_rdy(out_rdy), .out_id(out_id),
    .out_phase(out_phase), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Job-level model: a job is (id, d) emitting d*mult[beat] for beats 0..3.
  int       mult [4] = '{1, 3, 7, 8};
  int       m_last, m_id, m_d, m_beat, m_out;
  bit       m_act, m_vld;
  logic [N-1:0] m_grant;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_last = N - 1; m_act = 0; m_vld = 0; m_id = 0; m_d = 0;
      m_beat = 0; m_out = 0; m_grant = '0;
    end else begin
      bit adv;
      int w;
      m_grant = '0;
      adv = !m_vld || out_rdy;
      if (adv) begin
        if (!m_act || m_beat == 3) begin
          w = -1;
          for (int k = 1; k <= N; k++)
            if (w < 0 && req[(m_last + k) % N]) w = (m_last + k) % N;
          if (w >= 0) begin
            m_act = 1; m_vld = 1; m_id = w; m_last = w; m_beat = 0;
            m_d = int'((d_flat >> (DW * w)) & 32'hFF);
            m_out = m_d * mult[0];
            m_grant = N'(1 << w);
          end else begin
            m_act = 0; m_vld = 0;
          end
        end else begin
          m_beat++;
          m_out = m_d * mult[m_beat];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model grant", grant, m_grant);
      chk("model out_vld", out_vld, m_vld);
      chk("model busy", busy, m_act);
      chk("model out", out, m_out);
      if (m_vld) begin
        chk("model out_id", out_id, m_id);
        chk("model out_phase", out_phase, m_beat);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst out", out, 0);
    chk("rst out_vld", out_vld, 0);
    chk("rst grant", grant, 0);
    chk("rst busy", busy, 0);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic wait_grant(input logic [N-1:0] exp, input string name);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (grant !== '0) break;
    end
    chk(name, grant, exp);
  endtask

  initial begin
    int exp1 [4] = '{255, 765, 1785, 2040};
    logic [N-1:0] eg;
    #2 rst = 1'b1;
    #1;
    chk("rst0 out", out, 0);
    chk("rst0 out_vld", out_vld, 0);
    chk("rst0 busy", busy, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    started = 1;

    // 1: single job d=255
    @(negedge clk);
    d_flat[7:0] = 8'd255;
    req = 4'b0001;
    @(negedge clk);
    chk("t1 grant", grant, 4'b0001);
    chk("t1 out0", out, 255);
    chk("t1 id", out_id, 0);
    req = 4'b0000;
    for (int b = 1; b < 4; b++) begin
      @(negedge clk);
      chk("t1 out", out, exp1[b]);
      chk("t1 phase", out_phase, b);
      chk("t1 grant low", grant, 0);
    end
    @(negedge clk);
    chk("t1 idle vld", out_vld, 0);
    chk("t1 idle busy", busy, 0);

    // 2: round robin, all requesting
    do_reset();
    @(negedge clk);
    d_flat = 32'h04030201;
    req = 4'b1111;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      eg = (c % 4 == 0) ? N'(1 << ((c / 4) % 4)) : '0;
      chk("t2 grant", grant, eg);
      case (c)
        0:  chk("t2 out", out, 1);
        4:  chk("t2 out", out, 2);
        5:  chk("t2 out", out, 6);
        6:  chk("t2 out", out, 14);
        7:  chk("t2 out", out, 16);
        8:  chk("t2 out", out, 3);
        12: chk("t2 out", out, 4);
        default: ;
      endcase
    end
    req = 4'b0000;
    repeat (6) @(negedge clk);

    // 3: back-pressure during job d=10
    do_reset();
    d_flat = '0;
    d_flat[15:8]  = 8'd10;
    d_flat[23:16] = 8'd7;
    @(negedge clk);
    req = 4'b0010;
    wait_grant(4'b0010, "t3 grant");
    chk("t3 out0", out, 10);
    req = 4'b0000;
    @(negedge clk);
    chk("t3 out1", out, 30);
    out_rdy = 1'b0;
    req = 4'b0100;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("t3 stall out", out, 30);
      chk("t3 stall phase", out_phase, 1);
      chk("t3 stall grant", grant, 0);
    end
    out_rdy = 1'b1;
    @(negedge clk);
    chk("t3 out2", out, 70);
    @(negedge clk);
    chk("t3 out3", out, 80);
    @(negedge clk);
    chk("t3 next grant", grant, 4'b0100);
    chk("t3 next out", out, 7);
    req = 4'b0000;
    repeat (5) @(negedge clk);

    // 4: withdrawal of requester 1
    do_reset();
    d_flat = 32'h00332211;
    @(negedge clk);
    req = 4'b0001;
    wait_grant(4'b0001, "t4 grant0");
    req = 4'b0110;
    @(negedge clk);
    @(negedge clk);
    req = 4'b0100;
    wait_grant(4'b0100, "t4 grant2");
    chk("t4 id", out_id, 2);
    chk("t4 out", out, 8'h33);
    req = 4'b0000;
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      chk("t4 no grant1", grant[1], 0);
      if (out_vld) chk("t4 no id1", out_id, 2);
    end

    // 5: reset mid-job
    do_reset();
    d_flat = 32'd5;
    @(negedge clk);
    req = 4'b0001;
    wait_grant(4'b0001, "t5 grant");
    req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    chk("t5 phase2", out_phase, 2);
    chk("t5 out2", out, 35);
    #2 rst = 1'b1;
    #1;
    chk("t5 rst out", out, 0);
    chk("t5 rst vld", out_vld, 0);
    chk("t5 rst grant", grant, 0);
    chk("t5 rst busy", busy, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("t5 quiet vld", out_vld, 0);
    end
    req = 4'b0001;
    @(negedge clk);
    chk("t5 regrant", grant, 4'b0001);
    req = 4'b0000;
    repeat (5) @(negedge clk);

    // 6: zero operand
    d_flat = '0;
    @(negedge clk);
    req = 4'b0001;
    wait_grant(4'b0001, "t6 grant");
    req = 4'b0000;
    chk("t6 out", out, 0);
    chk("t6 vld", out_vld, 1);
    for (int b = 1; b < 4; b++) begin
      @(negedge clk);
      chk("t6 out", out, 0);
      chk("t6 vld", out_vld, 1);
      chk("t6 phase", out_phase, b);
    end
    @(negedge clk);
    chk("t6 done vld", out_vld, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mult_sched.md
Name: mult_sched

Overview:
- Round-robin scheduler that shares one 4-phase shift-add constant-multiply engine among N_REQ requesters.
- Each granted 8-bit operand d produces four results, one per phase, in order: d*1, d*3, d*7, d*8.
- The engine is embedded; it never uses a multiplier, only shifts and add/subtract.
- Sits between the requesting front-end channels and the single downstream result consumer, which applies back-pressure through out_rdy.

Parameters:
- N_REQ, 4, number of requesters; supported range is 2 to 8.
- DW, 8, operand width.
- OW, 11, result width; must be DW+3, since 255*8 = 2040 fits 11 bits.
- IDW, 2, requester-ID width; must be clog2(N_REQ).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester request level, held until granted.
- d_flat  input  N_REQ*DW  packed operands; requester i uses bits [i*DW +: DW].
- grant  output  N_REQ  one-hot, one-cycle pulse; marks the edge on which the requester's operand was captured.
- out  output  OW  current phase result.
- out_vld  output  1  out, out_id and out_phase are valid.
- out_rdy  input  1  consumer accepts the result when out_vld && out_rdy.
- out_id  output  IDW  requester that owns the current result.
- out_phase  output  2  0 = d*1, 1 = d*3, 2 = d*7, 3 = d*8.
- busy  output  1  high while a job occupies the engine.

Behaviour:
- Reset (asynchronous, takes effect immediately): the following all clear to 0: grant, out, out_vld, out_id, out_phase, busy, d_reg, phase. The state goes to IDLE and the round-robin pointer last_id goes to N_REQ-1, so requester 0 has top priority after reset.
- Reset mid-job: the partial job is dropped. No further out_vld for it, and no re-grant of it.
- FSM states are IDLE and RUN; phase is a 2-bit counter.
- Advance condition: adv = !out_vld || out_rdy. When adv = 0, all registers hold, including out, which must stay stable during a stall.
- Arbitration happens on an edge with adv = 1 when either the state is IDLE, or the state is RUN and phase == 3.
  - Search order is last_id+1, last_id+2, ... modulo N_REQ; the first i with req[i] = 1 wins.
- If a winner i exists, then on that edge:
  - grant = one-hot(i) for exactly one cycle.
  - d_reg <= operand i; out <= operand i (the d*1 result, zero-extended).
  - out_vld <= 1, out_phase <= 0, out_id <= i, last_id <= i.
  - state <= RUN, phase <= 0, busy <= 1.
- If no winner exists, then on that edge: state <= IDLE, out_vld <= 0, busy <= 0, and out holds its last value.
- RUN with adv = 1 and phase 0, 1 or 2: phase increments, out_phase follows it, out_vld stays 1, and out updates as follows:
  - phase 0 to 1: out <= d_reg + (d_reg<<1).
  - phase 1 to 2: out <= (d_reg<<3) - d_reg.
  - phase 2 to 3: out <= d_reg<<3.
- Arithmetic is unsigned, OW bits wide. Operands are zero-extended before shifting, and no overflow is possible.
- Latency and throughput:
  - The phase-0 result is valid in the cycle after the grant edge (grant and out_vld rise together).
  - A job is 4 accepted beats.
  - Back-to-back jobs have no bubble: the edge that retires phase 3 is the next job's grant edge.
  - Sustained throughput is 1 result per cycle, i.e. 1 job per 4 cycles, when out_rdy = 1.
- req handling:
  - req is sampled only on arbitration edges.
  - A requester that deasserts before its grant is treated as withdrawn.
  - A requester still asserting req after its grant is a new request.
  - Under round robin it is served after all other active requesters.
- grant never fires while a job is in phases 0 to 2 or while stalled. Exactly one grant per job.
- busy = (state == RUN). It falls only on an arbitration edge that finds no winner.

Test Plan:
1. Single job, out_rdy = 1: after reset, req = 0001 with d0 = 8'd255 -> grant = 0001 for one cycle; then 4 consecutive beats out = 255, 765, 1785, 2040 with out_phase 0,1,2,3 and out_id = 0; then out_vld = 0 and busy = 0.
2. Round robin: req = 1111 held, operands 1,2,3,4, out_rdy = 1 -> grants in order 0001, 0010, 0100, 1000, 0001, each 4 cycles apart with no bubble; the first d*1 results are 1,2,3,4; job 1 (d = 2) yields 2, 6, 14, 16.
3. Back-pressure: during job d = 10, hold out_rdy = 0 for 3 cycles at phase 1 -> out stays 30 with out_phase = 1 for those cycles; there is no grant during the stall, and the sequence resumes 70, 80.
4. Withdrawal: req = 0110 while job 0 runs; drop req[1] before the arbitration edge -> grant = 0100 (requester 2); requester 1 gets no grant and no results.
5. Reset mid-operation: assert rst at phase 2 of job d = 5 -> out, out_vld, grant and busy all read 0 immediately; after release with req = 0000, out_vld stays 0; with req = 0001, the first grant is 0001.
6. Edge operand: d = 0 -> four beats, each with out = 0 and out_vld = 1.
